spi_master_tx: RTL and testbench

SPI_MASTER_TX -- requirements
Module: spi_master_tx

---
 rtl/spi_pkg.sv | 14 +
 rtl/spi_clk_gen.sv | 39 +++
 rtl/spi_master_tx.sv | 114 +++++++++++
 tb/tb_spi_master_tx.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and default constants for the SPI master transmitter.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    SHIFT,
    DONE
  } spi_state_t;

  localparam int SPI_DATA_W  = 8;
  localparam int SPI_CLK_DIV = 2;

endpackage

// File: rtl/spi_clk_gen.sv
// Half-period timer for the SPI master: counts CLK_DIV clk cycles per SCLK phase
// and flags the edge that should raise (rise) or lower (fall) SCLK.
module spi_clk_gen
  import spi_pkg::*;
#(
  parameter int CLK_DIV = SPI_CLK_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic rise,
  output logic fall
);

  localparam int CNT_W = $clog2(CLK_DIV + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt;
  logic             phase;
  logic             wrap;

  // phase mirrors SCLK: low through SETUP, then alternating each half-period
  assign wrap = en && (cnt == LAST);
  assign rise = wrap && !phase;
  assign fall = wrap && phase;

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (cnt == LAST) begin
      cnt   <= '0;
      phase <= ~phase;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_master_tx.sv
// SPI mode-0 master, MSB first, one frame per start request.
// Define SPI_LOOPBACK_EN to receive the master's own mosi instead of the miso pin.
module spi_master_tx
  import spi_pkg::*;
#(
  parameter int DATA_W  = SPI_DATA_W,
  parameter int CLK_DIV = SPI_CLK_DIV
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  output logic              ready,
  output logic              done,
  output logic [DATA_W-1:0] rx_data,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic              cs_n
);

  localparam int BIT_W = $clog2(DATA_W) + 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W);

  spi_state_t        state, state_nxt;
  logic [DATA_W-1:0] tx_shift;
  logic [DATA_W-1:0] rx_shift;
  logic [BIT_W-1:0]  bit_cnt;
  logic              rise, fall, en, last_bit, sample_bit;

  spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .rise (rise),
    .fall (fall)
  );

  assign en       = (state == SETUP) || (state == SHIFT);
  assign last_bit = (bit_cnt == LAST_BIT);
  assign ready    = (state == IDLE);
  assign done     = (state == DONE);
  assign mosi     = tx_shift[DATA_W-1];

`ifdef SPI_LOOPBACK_EN
  logic unused_miso;
  assign unused_miso = miso;
  assign sample_bit  = mosi;
`else
  assign sample_bit  = miso;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SETUP;
      SETUP:   if (rise) state_nxt = SHIFT;
      // a rise strobe after the last low half-period ends the frame instead
      SHIFT:   if (rise && last_bit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_shift <= '0;
      rx_shift <= '0;
      rx_data  <= '0;
      bit_cnt  <= '0;
      cs_n     <= 1'b1;
      sclk     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            tx_shift <= tx_data;
            bit_cnt  <= '0;
            cs_n     <= 1'b0;
            sclk     <= 1'b0;
          end
        end
        SETUP: begin
          if (rise) begin
            sclk     <= 1'b1;
            rx_shift <= {rx_shift[DATA_W-2:0], sample_bit};
          end
        end
        SHIFT: begin
          if (fall) begin
            sclk     <= 1'b0;
            tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
            bit_cnt  <= bit_cnt + 1'b1;
          end else if (rise) begin
            if (last_bit) begin
              cs_n    <= 1'b1;
              rx_data <= rx_shift;
            end else begin
              sclk     <= 1'b1;
              rx_shift <= {rx_shift[DATA_W-2:0], sample_bit};
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_tx.sv
// Scoreboard bench for spi_master_tx: a mode-0 slave model feeds miso, a monitor
// collects mosi bits, SCLK pulses and latency per frame and compares at done.
module tb_spi_master_tx;

`ifdef SPI_LOOPBACK_EN
  localparam int CDIV = 1;
  localparam bit LOOP = 1'b1;
`else
  localparam int CDIV = 2;
  localparam bit LOOP = 1'b0;
`endif
  localparam int LAT = CDIV + 2 * CDIV * 8 + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       ready, done, sclk, mosi, miso, cs_n;
  logic [7:0] rx_data;

  spi_master_tx #(.DATA_W(8), .CLK_DIV(CDIV)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .tx_data (tx_data),
    .ready   (ready),
    .done    (done),
    .rx_data (rx_data),
    .sclk    (sclk),
    .mosi    (mosi),
    .miso    (miso),
    .cs_n    (cs_n)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // mode-0 slave: first bit valid when cs_n falls, next bit after each SCLK fall
  logic [7:0] slave_word = 8'h00;
  logic [7:0] slv_sh = 8'h00;
  always @(negedge cs_n) slv_sh <= slave_word;
  always @(negedge sclk) if (!cs_n) slv_sh <= {slv_sh[6:0], 1'b0};
  assign miso = slv_sh[7];

  typedef struct packed {
    logic [7:0] mosi;
    logic [7:0] rx;
  } exp_t;
  exp_t sb[$];

  int n_chk = 0;
  int n_pass = 0;
  int n_done = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  logic       prev_ready = 1'b1, prev_sclk = 1'b0, prev_done = 1'b0;
  logic       in_frame = 1'b0, ready_bad = 1'b0, after_done = 1'b0;
  logic [7:0] mon_mosi = 8'h00;
  int         pulses = 0, acc_cyc = 0, gap = 0, last_gap = -1;
  exp_t       e;

  always @(negedge clk) begin
    if (rst) begin
      in_frame = 1'b0;
    end else begin
      if (prev_ready && !ready) begin
        in_frame  = 1'b1;
        ready_bad = 1'b0;
        mon_mosi  = 8'h00;
        pulses    = 0;
        acc_cyc   = cyc;
        if (after_done) last_gap = gap;
        after_done = 1'b0;
      end else if (in_frame && ready) begin
        ready_bad = 1'b1;
      end
      if (in_frame && sclk && !prev_sclk) begin
        mon_mosi = {mon_mosi[6:0], mosi};
        pulses++;
      end
      if (prev_done) check("done_width", 32'(done), 32'd0);
      if (after_done && ready && cs_n) gap++;
      if (done) begin
        n_done++;
        if (sb.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("rx_data", 32'(rx_data), 32'(e.rx));
          check("mosi_bits", 32'(mon_mosi), 32'(e.mosi));
          check("sclk_pulses", 32'(pulses), 32'd8);
          // cycles from the accepting edge to the edge that samples done
          check("done_latency", 32'(cyc - acc_cyc + 1), 32'(LAT));
          check("done_cs_n", 32'(cs_n), 32'd1);
          check("ready_low", 32'({ready, ready_bad}), 32'd0);
        end
        in_frame   = 1'b0;
        after_done = 1'b1;
        gap        = 0;
      end
    end
    prev_ready = ready;
    prev_sclk  = sclk;
    prev_done  = done;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] tx, input logic [7:0] slv, input int hold, input bit push);
    tx_data    = tx;
    slave_word = slv;
    start      = 1'b1;
    if (push) sb.push_back('{mosi: tx, rx: (LOOP ? tx : slv)});
    repeat (hold) tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int nd);
    int i;
    i = 0;
    while (n_done <= nd && i < 200) begin
      tick();
      i++;
    end
    if (n_done <= nd) check("done_timeout", 32'd0, 32'd1);
  endtask

  int nd;

  initial begin
    repeat (3) tick();
    check("rst_outputs", 32'({ready, done, cs_n, sclk, mosi}), 32'b10100);
    check("rst_rx", 32'(rx_data), 32'd0);

    start   = 1'b1;
    tx_data = 8'hAA;
    tick();
    check("rst_over_start", 32'({ready, cs_n, sclk}), 32'b110);
    start = 1'b0;
    rst   = 1'b0;

    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle", 32'({ready, done, cs_n, sclk}), 32'b1010);
    end

    nd = n_done;
    send(8'hA5, 8'h3C, 1, 1'b1);
    wait_done(nd);
    repeat (3) tick();

    nd = n_done;
    send(8'h69, 8'hC6, 4, 1'b1);
    wait_done(nd);
    repeat (10) tick();
    check("held_one_frame", 32'(n_done - nd), 32'd1);

    nd = n_done;
    send(8'hFF, 8'h81, 1, 1'b1);
    wait_done(nd);
    tick();
    send(8'h00, 8'h96, 1, 1'b1);
    wait_done(nd + 1);
    check("b2b_idle_gap", 32'(last_gap), 32'd1);

    repeat (3) tick();
    nd = n_done;
    send(8'hC3, 8'h5A, 1, 1'b0);
    repeat (11) tick();
    rst = 1'b1;
    tick();
    check("abort_outputs", 32'({ready, done, cs_n, sclk}), 32'b1010);
    check("abort_rx", 32'(rx_data), 32'd0);
    rst = 1'b0;
    repeat (50) tick();
    check("abort_no_done", 32'(n_done - nd), 32'd0);

    nd = n_done;
    send(8'h5A, 8'hE7, 1, 1'b1);
    wait_done(nd);
    repeat (3) tick();
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
